trace_frame_assembler: RTL and testbench
========================================

TRACE_FRAME_ASSEMBLER -- requirements
Module: trace_frame_assembler

Interface
REQ-001 The block SHALL have parameter FRAME_WORDS, default 8, giving the number of 16-bit words per TPIU frame (16 bytes).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, giving the width of the statistics counters.
REQ-003 Port clk, input, 1: single system clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port sync, input, 1: trace interface in sync.
REQ-006 Port WdAvail, input, 1: one-cycle strobe marking PacketWd valid.
REQ-007 Port PacketWd, input, 16: incoming trace word.
REQ-008 Port PacketReset, input, 1: one-cycle strobe that aborts the partial frame.
REQ-009 Port outValid, output, 1: outWord is valid.
REQ-010 Port outReady, input, 1: consumer accepts outWord.
REQ-011 Port outWord, output, 16: frame word.
REQ-012 Port outFirst / outLast, output, 1 each: marks word index 0 / FRAME_WORDS-1.
REQ-013 Port overflow, output, 1: one-cycle pulse for each frame dropped.
REQ-014 Port frameCount / dropCount, output, CNT_WIDTH each: present only with FRAME_STATS_EN.

Function
REQ-015 Storage SHALL be two frame buffers (ping-pong), each FRAME_WORDS x 16, with a full flag per buffer.
REQ-016 Writer states SHALL be FILL and DROP; the write index SHALL run 0..FRAME_WORDS-1.
REQ-017 FILL: each WdAvail SHALL store PacketWd at the write index and increment it. When the last index is stored, the buffer's full flag SHALL set, the write buffer SHALL toggle and the index SHALL return to 0.
REQ-018 On WdAvail at index 0 with the target buffer full, the word SHALL be discarded and the writer SHALL enter DROP with index 1.
REQ-019 DROP: words SHALL be counted but not stored. On completing FRAME_WORDS words, overflow SHALL pulse one cycle, the index SHALL return to 0 and the writer SHALL return to FILL.
REQ-020 PacketReset, or sync low, SHALL force index 0 and state FILL and discard the partial frame; it SHALL NOT count as a drop. Words arriving while sync is low SHALL be ignored.
REQ-021 Release has priority: if the reader frees a buffer in the same cycle as a first-word WdAvail targets it, the word SHALL be accepted in FILL.
REQ-022 Reader states SHALL be IDLE and SEND. In IDLE, SEND SHALL be entered when the read buffer's full flag is set.
REQ-023 In SEND, outValid SHALL be 1 and outWord SHALL equal buf[rd][index]. Each cycle with outValid&outReady SHALL advance the index. Accepting the last word SHALL clear the full flag, toggle the read buffer and return to IDLE.
REQ-024 outWord, outFirst and outLast SHALL hold stable while outValid is high and outReady is low.
REQ-025 Latency: outValid SHALL rise two cycles after the cycle of the frame's final WdAvail (full flag set, then SEND entered).
REQ-026 A frame already complete SHALL still be delivered after sync drops.

Reset
REQ-027 rst SHALL clear both full flags, set the write and read buffer selects and indices to 0, writer to FILL, reader to IDLE, and outValid, outFirst, outLast, overflow and the counters to 0.
REQ-028 rst mid-frame SHALL discard all buffered data; buffer RAM contents need not be cleared.

Configuration
REQ-029 With FRAME_STATS_EN defined, frameCount SHALL increment per delivered frame and dropCount per overflow pulse, both saturating at all-ones.
REQ-030 Without FRAME_STATS_EN, both counter ports and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package trace_pkg SHALL hold the 16-bit word type, the default FRAME_WORDS, and the writer and reader state enums.
REQ-032 One sub-module, frame_pingpong_buf (dual 16-bit buffer with one write port and one read port), SHALL hold the storage.

Verification
REQ-033 Check: 8 WdAvail words 0x0001..0x0008, outReady=1 -> outValid 2 cycles after the last word; 0x0001 with outFirst; 0x0008 with outLast; frameCount=1.
REQ-034 Check: 24 words back-to-back, outReady=0 -> frames 1 and 2 held, frame 3 dropped, one overflow pulse, dropCount=1. Then outReady=1 -> 16 words in order.
REQ-035 Check: 5 words, PacketReset, 8 words 0xA000..0xA007 -> exactly one frame, 0xA000..0xA007, no overflow.
REQ-036 Check: outReady toggled every cycle during a frame -> no word lost or duplicated, outputs stable while stalled.
REQ-037 Check: both buffers full, reader frees one in the same cycle as a new first word -> new frame accepted and delivered, overflow stays 0.
REQ-038 Check: rst asserted mid-SEND at word 3 -> next cycle outValid=0, counters 0, and a subsequent frame is delivered cleanly.

Source files
------------

// File: rtl/trace_pkg.sv
// ============================================================================
// Module   : trace_pkg
// Purpose  : Shared word type, default frame size and FSM state encodings.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package trace_pkg;

  localparam int unsigned c_WORD_W              = 16;
  localparam int unsigned c_FRAME_WORDS_DEFAULT = 8;

  typedef logic [c_WORD_W-1:0] word_t;

  typedef enum logic {
    WR_FILL = 1'b0,
    WR_DROP = 1'b1
  } wr_state_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } rd_state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_pingpong_buf.sv
// ============================================================================
// Module   : frame_pingpong_buf
// Purpose  : Two FRAME_WORDS x 16 frame buffers, one write port, one read port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_pingpong_buf
  import trace_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = c_FRAME_WORDS_DEFAULT,
  parameter int unsigned IDX_W       = idx_width(FRAME_WORDS)
) (
  input  logic                clk,
  input  logic                wr_en_i,
  input  logic                wr_sel_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [c_WORD_W-1:0] wr_data_i,
  input  logic                rd_sel_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output logic [c_WORD_W-1:0] rd_data_o
);

  // Storage is deliberately not reset; the full flags qualify its contents.
  word_t mem_q [2][FRAME_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_sel_i][wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_sel_i][rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/trace_frame_assembler.sv
// ============================================================================
// Module   : trace_frame_assembler
// Purpose  : Packs trace words into fixed-size frames through a ping-pong
//            buffer; frames arriving with both buffers full are dropped.
//            Optional statistics counters: define FRAME_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module trace_frame_assembler
  import trace_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = c_FRAME_WORDS_DEFAULT,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sync,
  input  logic                WdAvail,
  input  logic [15:0]         PacketWd,
  input  logic                PacketReset,
  output logic                outValid,
  input  logic                outReady,
  output logic [15:0]         outWord,
  output logic                outFirst,
  output logic                outLast,
  output logic                overflow
`ifdef FRAME_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] frameCount,
  output logic [CNT_WIDTH-1:0] dropCount
`endif
);

  localparam int unsigned        c_IDX_W    = idx_width(FRAME_WORDS);
  localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(FRAME_WORDS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

  if (FRAME_WORDS < 2) begin : g_bad_frame_words
    $error("FRAME_WORDS must be at least 2");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("CNT_WIDTH must be at least 1");
  end

  wr_state_e          wr_state_q;
  logic               wr_sel_q;
  logic [c_IDX_W-1:0] wr_idx_q;
  rd_state_e          rd_state_q;
  logic               rd_sel_q;
  logic [c_IDX_W-1:0] rd_idx_q;
  logic [1:0]         full_q;
  logic [1:0]         full_d;
  logic               out_valid_q;
  logic               out_first_q;
  logic               out_last_q;
  logic               overflow_q;

  logic               wr_accept;
  logic               rd_release;
  logic               target_busy;
  logic               wr_store;
  logic               wr_frame_done;
  logic               drop_done;
  logic [c_IDX_W-1:0] wr_idx_inc;
  logic [c_IDX_W-1:0] rd_idx_inc;

  assign wr_idx_inc    = wr_idx_q + 1'b1;
  assign rd_idx_inc    = rd_idx_q + 1'b1;
  assign wr_accept     = sync && !PacketReset && WdAvail;
  assign rd_release    = (rd_state_q == RD_SEND) && outReady && (rd_idx_q == c_LAST_IDX);
  // A buffer freed by the reader this cycle is already usable by the writer.
  assign target_busy   = full_q[wr_sel_q] && !(rd_release && (rd_sel_q == wr_sel_q));
  assign wr_store      = wr_accept && (wr_state_q == WR_FILL) &&
                         !((wr_idx_q == '0) && target_busy);
  assign wr_frame_done = wr_store && (wr_idx_q == c_LAST_IDX);
  assign drop_done     = wr_accept && (wr_state_q == WR_DROP) && (wr_idx_q == c_LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_FILL;
      wr_sel_q   <= 1'b0;
      wr_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= drop_done;
      if (!sync || PacketReset) begin
        wr_state_q <= WR_FILL;
        wr_idx_q   <= '0;
      end else if (WdAvail) begin
        case (wr_state_q)
          WR_FILL: begin
            if (!wr_store) begin
              wr_state_q <= WR_DROP;
              wr_idx_q   <= c_IDX_ONE;
            end else if (wr_frame_done) begin
              wr_idx_q <= '0;
              wr_sel_q <= !wr_sel_q;
            end else begin
              wr_idx_q <= wr_idx_inc;
            end
          end
          WR_DROP: begin
            if (drop_done) begin
              wr_state_q <= WR_FILL;
              wr_idx_q   <= '0;
            end else begin
              wr_idx_q <= wr_idx_inc;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    full_d = full_q;
    if (rd_release) begin
      full_d[rd_sel_q] = 1'b0;
    end
    if (wr_frame_done) begin
      full_d[wr_sel_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 2'b00;
    end else begin
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q  <= RD_IDLE;
      rd_sel_q    <= 1'b0;
      rd_idx_q    <= '0;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (full_q[rd_sel_q]) begin
            rd_state_q  <= RD_SEND;
            rd_idx_q    <= '0;
            out_valid_q <= 1'b1;
            out_first_q <= 1'b1;
            out_last_q  <= 1'b0;
          end
        end
        RD_SEND: begin
          if (outReady) begin
            if (rd_idx_q == c_LAST_IDX) begin
              rd_state_q  <= RD_IDLE;
              rd_sel_q    <= !rd_sel_q;
              rd_idx_q    <= '0;
              out_valid_q <= 1'b0;
              out_first_q <= 1'b0;
              out_last_q  <= 1'b0;
            end else begin
              rd_idx_q    <= rd_idx_inc;
              out_first_q <= 1'b0;
              out_last_q  <= (rd_idx_inc == c_LAST_IDX);
            end
          end
        end
      endcase
    end
  end

  frame_pingpong_buf #(
    .FRAME_WORDS (FRAME_WORDS),
    .IDX_W       (c_IDX_W)
  ) u_buf (
    .clk       (clk),
    .wr_en_i   (wr_store),
    .wr_sel_i  (wr_sel_q),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (PacketWd),
    .rd_sel_i  (rd_sel_q),
    .rd_idx_i  (rd_idx_q),
    .rd_data_o (outWord)
  );

  assign outValid = out_valid_q;
  assign outFirst = out_first_q;
  assign outLast  = out_last_q;
  assign overflow = overflow_q;

`ifdef FRAME_STATS_EN
  logic [CNT_WIDTH-1:0] frame_cnt_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (rd_release && (frame_cnt_q != '1)) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (drop_done && (drop_cnt_q != '1)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign frameCount = frame_cnt_q;
  assign dropCount  = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_trace_frame_assembler.sv
// ============================================================================
// Module   : tb_trace_frame_assembler
// Purpose  : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_trace_frame_assembler;

  localparam int FW = 8;
  localparam int CW = 16;

  logic        clk = 1'b0;
  logic        rst, sync, WdAvail, PacketReset, outReady;
  logic [15:0] PacketWd;
  logic        outValid, outFirst, outLast, overflow;
  logic [15:0] outWord;
`ifdef FRAME_STATS_EN
  logic [CW-1:0] frameCount, dropCount;
`endif

  int checks = 0;
  int errors = 0;

  trace_frame_assembler #(.FRAME_WORDS(FW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .sync        (sync),
    .WdAvail     (WdAvail),
    .PacketWd    (PacketWd),
    .PacketReset (PacketReset),
    .outValid    (outValid),
    .outReady    (outReady),
    .outWord     (outWord),
    .outFirst    (outFirst),
    .outLast     (outLast),
    .overflow    (overflow)
`ifdef FRAME_STATS_EN
    ,
    .frameCount  (frameCount),
    .dropCount   (dropCount)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: completed frames awaiting delivery, the frame being
  // gathered, and how many complete frames currently occupy storage.
  logic [15:0] exp_q[$];
  logic [15:0] part_q[$];
  logic [15:0] got_q[$];
  bit          dropping;
  int          drop_words, held, pos, frames_done, ovf_exp, ovf_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic model_clear();
    exp_q.delete(); part_q.delete(); got_q.delete();
    dropping = 0; drop_words = 0; held = 0; pos = 0;
    frames_done = 0; ovf_exp = 0; ovf_seen = 0;
  endtask

  task automatic chk_counters(input string name);
`ifdef FRAME_STATS_EN
    chk({name, "_frameCount"}, frameCount, frames_done);
    chk({name, "_dropCount"}, dropCount, ovf_exp);
`endif
  endtask

  task automatic cycle(input bit av, input logic [15:0] wd, input bit pr,
                       input bit sy, input bit rdy);
    bit exp_ovf_now;
    WdAvail = av; PacketWd = wd; PacketReset = pr; sync = sy; outReady = rdy;
    if (outValid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", outValid, 0);
      end else begin
        chk("word", outWord, exp_q[0]);
        chk("first", outFirst, pos == 0);
        chk("last", outLast, pos == FW - 1);
        if (rdy) begin
          got_q.push_back(outWord);
          void'(exp_q.pop_front());
          if (pos == FW - 1) begin
            pos = 0; held--; frames_done++;
          end else begin
            pos++;
          end
        end
      end
    end
    exp_ovf_now = 0;
    if (!sy || pr) begin
      part_q.delete(); dropping = 0;
    end else if (av) begin
      if (dropping) begin
        drop_words++;
        if (drop_words == FW) begin
          dropping = 0; exp_ovf_now = 1; ovf_exp++;
        end
      end else if (part_q.size() == 0 && held >= 2) begin
        dropping = 1; drop_words = 1;
      end else begin
        part_q.push_back(wd);
        if (part_q.size() == FW) begin
          foreach (part_q[i]) exp_q.push_back(part_q[i]);
          part_q.delete();
          held++;
        end
      end
    end
    @(posedge clk); #1;
    if (overflow === 1'b1) ovf_seen++;
    chk("overflow", overflow, exp_ovf_now);
  endtask

  task automatic do_reset();
    rst = 1; WdAvail = 0; PacketReset = 0; sync = 1; outReady = 0; PacketWd = '0;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    chk("rst_outValid", outValid, 0);
    chk("rst_outFirst", outFirst, 0);
    chk("rst_outLast", outLast, 0);
    chk("rst_overflow", overflow, 0);
    chk_counters("rst");
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 1, rdy);
  endtask

  task automatic chk_seq(input string name, input logic [15:0] base, input int n, input int off);
    for (int i = 0; i < n; i++) begin
      if (off + i < got_q.size()) chk(name, got_q[off + i], base + 16'(i));
      else chk({name, "_missing"}, got_q.size(), off + n);
    end
  endtask

  typedef struct {
    bit          av;
    logic [15:0] wd;
    bit          rdy;
    bit          ev;
    logic [15:0] ew;
    bit          ef;
    bit          el;
  } vec_t;

  vec_t tbl[18];

  initial begin
    int k, ovf0;
    rst = 1; sync = 1; WdAvail = 0; PacketReset = 0; outReady = 0; PacketWd = '0;
    for (int i = 0; i < 18; i++) begin
      tbl[i].av  = (i < 8);
      tbl[i].wd  = (i < 8) ? 16'(i + 1) : 16'h0;
      tbl[i].rdy = 1;
      tbl[i].ev  = (i >= 9 && i <= 16);
      tbl[i].ew  = (i >= 9 && i <= 16) ? 16'(i - 8) : 16'h0;
      tbl[i].ef  = (i == 9);
      tbl[i].el  = (i == 16);
    end
    do_reset();

    // Single frame: latency, markers and data ordering.
    for (int i = 0; i < 18; i++) begin
      chk("tbl_valid", outValid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_word", outWord, tbl[i].ew);
        chk("tbl_first", outFirst, tbl[i].ef);
        chk("tbl_last", outLast, tbl[i].el);
      end
      cycle(tbl[i].av, tbl[i].wd, 0, 1, tbl[i].rdy);
    end
    chk_seq("tbl_seq", 16'h0001, 8, 0);
    chk_counters("tbl");

    // Three frames into a stalled consumer: third frame dropped.
    got_q.delete(); ovf0 = ovf_seen;
    for (int i = 0; i < 24; i++) cycle(1, 16'h0100 + 16'(i), 0, 1, 0);
    idle(3, 0);
    chk("stall_ovf_pulses", ovf_seen - ovf0, 1);
    chk_counters("stall");
    idle(30, 1);
    chk("stall_got", got_q.size(), 16);
    chk_seq("stall_seq", 16'h0100, 16, 0);

    // Partial frame aborted by PacketReset.
    got_q.delete(); ovf0 = ovf_seen;
    for (int i = 0; i < 5; i++) cycle(1, 16'h0500 + 16'(i), 0, 1, 0);
    cycle(0, '0, 1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(1, 16'hA000 + 16'(i), 0, 1, 0);
    idle(20, 1);
    chk("abort_got", got_q.size(), 8);
    chk_seq("abort_seq", 16'hA000, 8, 0);
    chk("abort_ovf", ovf_seen - ovf0, 0);

    // Consumer toggling ready every cycle.
    got_q.delete();
    k = 0;
    for (int i = 0; i < 8; i++) begin cycle(1, 16'hB000 + 16'(i), 0, 1, k[0]); k++; end
    for (int i = 0; i < 30; i++) begin cycle(0, '0, 0, 1, k[0]); k++; end
    chk("toggle_got", got_q.size(), 8);
    chk_seq("toggle_seq", 16'hB000, 8, 0);

    // Release in the same cycle as a new first word.
    got_q.delete(); ovf0 = ovf_seen;
    for (int i = 0; i < 16; i++) cycle(1, 16'hC000 + 16'(i), 0, 1, 0);
    idle(3, 0);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      if (k == 0 && outValid && outLast) begin cycle(1, 16'hD000, 0, 1, 1); k = 1; end
      else if (k > 0 && k < 8) begin cycle(1, 16'hD000 + 16'(k), 0, 1, 1); k++; end
      else cycle(0, '0, 0, 1, 1);
    end
    idle(20, 1);
    chk("race_aligned", k, 8);
    chk("race_ovf", ovf_seen - ovf0, 0);
    chk("race_got", got_q.size(), 24);
    chk_seq("race_seq_a", 16'hC000, 16, 0);
    chk_seq("race_seq_b", 16'hD000, 8, 16);

    // Reset while the reader is mid-frame.
    for (int i = 0; i < 8; i++) cycle(1, 16'hE000 + 16'(i), 0, 1, 0);
    idle(2, 0);
    for (int i = 0; i < 10 && !(outValid && pos == 3); i++) cycle(0, '0, 0, 1, 1);
    chk("midsend_word3", outWord, 16'hE003);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 16'hF000 + 16'(i), 0, 1, 1);
    idle(15, 1);
    chk("post_rst_got", got_q.size(), 8);
    chk_seq("post_rst_seq", 16'hF000, 8, 0);
    chk_counters("post_rst");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 100) < 60, 16'($urandom), ($urandom % 100) < 2,
            !(($urandom % 100) < 3), $urandom % 2);
    end
    idle(40, 1);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_ovf_total", ovf_seen, ovf_exp);
    chk_counters("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
